pipe_dmem_lsu: RTL

Parametrised data-memory and load/store unit for the pipe_MIPS32 datapath. It replaces the flat word-only Mem access used for LW/SW. It adds byte, halfword and word accesses with sign or zero extension, alignment and range checking, and a configurable read latency. A valid/ready request channel and a valid/ready response channel with back-pressure let the MEM stage stall cleanly.

---
 rtl/pipe_dmem_lsu_if.sv | 26 ++
 rtl/pipe_dmem_lsu.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pipe_dmem_lsu_if.sv
// Request/response bundle between the MEM stage (master) and the data-memory LSU (slave).
interface pipe_dmem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_tag;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [4:0]  rsp_tag;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_tag, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_tag, rsp_err
    );
endinterface

// File: rtl/pipe_dmem_lsu.sv
// Data memory + load/store unit: byte/half/word access, credit flow control, in-order responses.
// Build option DMEM_MISALIGN_TRAP_EN: misaligned half/word faults instead of being force-aligned.
module pipe_dmem_lsu #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 1
) (
    input logic            clk1,
    input logic            rst_n,
    pipe_dmem_lsu_if.slave bus
);
    localparam int unsigned Words      = 2 ** ADDR_W;
    localparam int unsigned PtrW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [2:0]  CreditInit = 3'(LATENCY);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(LATENCY - 1);

    typedef struct packed {
        logic       we;
        logic       err;
        logic [1:0] size;
        logic       sgn;
        logic [1:0] lane;
        logic [4:0] tag;
    } meta_t;

    typedef struct packed {
        logic        err;
        logic [4:0]  tag;
        logic [31:0] rdata;
    } rsp_t;

    logic [31:0]       mem [Words];
    logic [31:0]       rd_q [LATENCY];
    meta_t             meta_q [LATENCY];
    logic [LATENCY-1:0] pv_q;
    rsp_t              fifo_q [LATENCY];
    logic [PtrW-1:0]   wptr_q, rptr_q;
    logic [2:0]        cnt_q, credits_q, credits_d;

    logic              accept, consume, push, pop, fifo_empty, pipe_valid;
    logic              misalign, err;
    logic [1:0]        lane;
    logic [ADDR_W-1:0] widx;
    logic [3:0]        be;
    logic [31:0]       wdata_lanes, shifted, ext;
    meta_t             m_out;
    rsp_t              pipe_rsp, head;

    assign accept        = bus.req_valid && bus.req_ready;
    assign consume       = bus.rsp_valid && bus.rsp_ready;
    assign bus.req_ready = (credits_q != 3'd0);

    // One credit per response slot downstream, so nothing accepted can ever be dropped.
    always_comb begin
        credits_d = credits_q - {2'b00, accept} + {2'b00, consume};
    end

    always_comb begin
        widx        = bus.req_addr[ADDR_W+1:2];
        misalign    = 1'b0;
        lane        = bus.req_addr[1:0];
`ifdef DMEM_MISALIGN_TRAP_EN
        misalign = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                   ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
        case (bus.req_size)
            2'b01:   lane = {bus.req_addr[1], 1'b0};
            2'b10:   lane = 2'b00;
            default: lane = bus.req_addr[1:0];
        endcase
`endif
        err = (bus.req_size == 2'b11) || (|bus.req_addr[31:ADDR_W+2]) || misalign;
        be          = 4'b0000;
        wdata_lanes = bus.req_wdata;
        case (bus.req_size)
            2'b00: begin
                be          = 4'b0001 << lane;
                wdata_lanes = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                be          = 4'b0011 << lane;
                wdata_lanes = {2{bus.req_wdata[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Array and read-data pipeline carry no reset; contents survive rst_n.
    always_ff @(posedge clk1) begin
        if (accept) begin
            if (bus.req_we && !err) begin
                for (int k = 0; k < 4; k++) begin
                    if (be[k]) mem[widx][8*k +: 8] <= wdata_lanes[8*k +: 8];
                end
            end
            rd_q[0] <= mem[widx];
        end
        for (int i = 1; i < LATENCY; i++) rd_q[i] <= rd_q[i-1];
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            pv_q <= '0;
            for (int i = 0; i < LATENCY; i++) meta_q[i] <= '0;
        end else begin
            pv_q[0] <= accept;
            if (accept) begin
                meta_q[0] <= '{we: bus.req_we, err: err, size: bus.req_size,
                               sgn: bus.req_signed, lane: lane, tag: bus.req_tag};
            end
            for (int i = 1; i < LATENCY; i++) begin
                pv_q[i]   <= pv_q[i-1];
                meta_q[i] <= meta_q[i-1];
            end
        end
    end

    always_comb begin
        m_out   = meta_q[LATENCY-1];
        shifted = rd_q[LATENCY-1] >> {m_out.lane, 3'b000};
        case (m_out.size)
            2'b00:   ext = {{24{m_out.sgn & shifted[7]}}, shifted[7:0]};
            2'b01:   ext = {{16{m_out.sgn & shifted[15]}}, shifted[15:0]};
            default: ext = rd_q[LATENCY-1];
        endcase
        pipe_rsp.err   = m_out.err;
        pipe_rsp.tag   = m_out.tag;
        pipe_rsp.rdata = (m_out.we || m_out.err) ? 32'd0 : ext;
    end

    // Fall-through queue: an empty queue with a ready consumer passes the pipeline straight out.
    assign pipe_valid = pv_q[LATENCY-1];
    assign fifo_empty = (cnt_q == 3'd0);
    assign push       = pipe_valid && !(fifo_empty && bus.rsp_ready);
    assign pop        = !fifo_empty && bus.rsp_ready;
    assign head       = fifo_empty ? pipe_rsp : fifo_q[rptr_q];

    assign bus.rsp_valid = !fifo_empty || pipe_valid;
    assign bus.rsp_rdata = bus.rsp_valid ? head.rdata : 32'd0;
    assign bus.rsp_tag   = bus.rsp_valid ? head.tag : 5'd0;
    assign bus.rsp_err   = bus.rsp_valid ? head.err : 1'b0;

    always_ff @(posedge clk1) begin
        if (push) fifo_q[wptr_q] <= pipe_rsp;
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= 3'd0;
            credits_q <= CreditInit;
        end else begin
            credits_q <= credits_d;
            cnt_q     <= cnt_q + {2'b00, push} - {2'b00, pop};
            if (push) wptr_q <= (wptr_q == PtrLast) ? '0 : wptr_q + 1'b1;
            if (pop)  rptr_q <= (rptr_q == PtrLast) ? '0 : rptr_q + 1'b1;
        end
    end
endmodule
